// File: rtl/zone_light_controller.sv
// Multi-zone lighting controller: per-zone debounce, short/long press decode, absence timer and AUTO/MANUAL FSM.
// Optional master-off input enabled with `define ZLC_MASTER_OFF_EN.
module zone_light_controller #(
    parameter int N_ZONES           = 4,
    parameter int CLK_PER_MS        = 50000,
    parameter int DEBOUNCE_P        = 300,
    parameter int SWITCH_MODE_MIN_T = 5000,
    parameter int AUTO_SHUTDOWN_T   = 30000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_ZONES-1:0] infravermelho,
    input  logic [N_ZONES-1:0] push_button,
`ifdef ZLC_MASTER_OFF_EN
    input  logic               all_off,
`endif
    output logic [N_ZONES-1:0] saida,
    output logic [N_ZONES-1:0] led
);

    localparam int PW = $clog2(CLK_PER_MS + 1);
    localparam int DW = $clog2(DEBOUNCE_P + 1);
    localparam int HW = $clog2(SWITCH_MODE_MIN_T + 1);
    localparam int AW = $clog2(AUTO_SHUTDOWN_T + 1);

    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_MS - 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_P - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(SWITCH_MODE_MIN_T);
    localparam logic [AW-1:0] ABS_MAX  = AW'(AUTO_SHUTDOWN_T);

    typedef enum logic [1:0] {
        AUTO_OFF,
        AUTO_ON,
        MANUAL_OFF,
        MANUAL_ON
    } zone_state_t;

    logic [PW-1:0] presc;
    logic          tick;
    logic          master_off;

    assign tick = (presc == PRE_LAST);

`ifdef ZLC_MASTER_OFF_EN
    assign master_off = all_off;
`else
    assign master_off = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    for (genvar z = 0; z < N_ZONES; z++) begin : g_zone
        logic          ir_m, ir_s;
        logic          pb_m, pb_s;
        logic          deb, deb_d;
        logic [DW-1:0] deb_cnt;
        logic [HW-1:0] hold_cnt;
        logic          long_seen;
        logic [AW-1:0] abs_cnt;
        logic          long_ev, short_ev, timeout, enter_on;
        logic          lamp, mode;
        zone_state_t   state, nxt;

        // long fires in the first cycle the hold count sits at its limit; long_seen masks the rest
        assign long_ev  = deb && (hold_cnt == HOLD_MAX) && !long_seen;
        // hold_cnt still holds the pre-release value in the first cycle after deb falls
        assign short_ev = deb_d && !deb && (hold_cnt != HOLD_MAX);
        assign timeout  = (abs_cnt >= ABS_MAX);

        always_comb begin
            nxt = state;
            if (long_ev) begin
                case (state)
                    AUTO_OFF:   nxt = MANUAL_OFF;
                    AUTO_ON:    nxt = MANUAL_ON;
                    MANUAL_OFF: nxt = AUTO_OFF;
                    MANUAL_ON:  nxt = AUTO_ON;
                    default:    nxt = AUTO_OFF;
                endcase
            end else if (master_off) begin
                case (state)
                    AUTO_ON:   nxt = AUTO_OFF;
                    MANUAL_ON: nxt = MANUAL_OFF;
                    default:   nxt = state;
                endcase
            end else begin
                case (state)
                    AUTO_OFF:   if (ir_s) nxt = AUTO_ON;
                    AUTO_ON:    if (timeout) nxt = AUTO_OFF;
                    MANUAL_OFF: if (short_ev) nxt = MANUAL_ON;
                    MANUAL_ON:  if (timeout || short_ev) nxt = MANUAL_OFF;
                    default:    nxt = AUTO_OFF;
                endcase
            end
        end

        assign enter_on = ((nxt == AUTO_ON) || (nxt == MANUAL_ON)) && (nxt != state);

        always_ff @(posedge clk) begin
            if (rst) begin
                ir_m      <= 1'b0;
                ir_s      <= 1'b0;
                pb_m      <= 1'b0;
                pb_s      <= 1'b0;
                deb       <= 1'b0;
                deb_d     <= 1'b0;
                deb_cnt   <= '0;
                hold_cnt  <= '0;
                long_seen <= 1'b0;
                abs_cnt   <= '0;
                state     <= AUTO_OFF;
                lamp      <= 1'b0;
                mode      <= 1'b0;
            end else begin
                ir_m  <= infravermelho[z];
                ir_s  <= ir_m;
                pb_m  <= push_button[z];
                pb_s  <= pb_m;
                deb_d <= deb;

                if (pb_s == deb) begin
                    deb_cnt <= '0;
                end else if (tick) begin
                    if (deb_cnt == DEB_LAST) begin
                        deb     <= pb_s;
                        deb_cnt <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end

                if (!deb) begin
                    hold_cnt <= '0;
                end else if (tick && (hold_cnt != HOLD_MAX)) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
                long_seen <= deb && (hold_cnt == HOLD_MAX);

                if (ir_s || enter_on || master_off) begin
                    abs_cnt <= '0;
                end else if (tick && !timeout) begin
                    abs_cnt <= abs_cnt + 1'b1;
                end

                state <= nxt;
                lamp  <= (nxt == AUTO_ON) || (nxt == MANUAL_ON);
                mode  <= (nxt == MANUAL_OFF) || (nxt == MANUAL_ON);
            end
        end

        assign saida[z] = lamp;
        assign led[z]   = mode;
    end

endmodule

// File: tb/tb_zone_light_controller.sv
// Scoreboard bench for zone_light_controller: stimulus queues expected {saida,led} values,
// a monitor pops one on every output change. Define ZLC_MASTER_OFF_EN to exercise all_off.
module tb_zone_light_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] ir  = '0;
    logic [1:0] pb  = '0;
`ifdef ZLC_MASTER_OFF_EN
    logic       all_off = 1'b0;
`endif
    logic [1:0] saida, led;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [3:0] expq[$];
    logic       mon_en = 1'b0;
    logic [3:0] prev;
    logic [3:0] mon_exp;

    always #5 clk = ~clk;

    zone_light_controller #(
        .N_ZONES(2),
        .CLK_PER_MS(4),
        .DEBOUNCE_P(3),
        .SWITCH_MODE_MIN_T(20),
        .AUTO_SHUTDOWN_T(50)
    ) dut (
        .clk(clk),
        .rst(rst),
        .infravermelho(ir),
        .push_button(pb),
`ifdef ZLC_MASTER_OFF_EN
        .all_off(all_off),
`endif
        .saida(saida),
        .led(led)
    );

    // Monitor: every change of {saida,led} must match the oldest queued expectation
    always @(negedge clk) begin
        if (mon_en && ({saida, led} !== prev)) begin
            vectors++;
            if (expq.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_change: got %b, required %b (no change)", {saida, led}, prev);
            end else begin
                mon_exp = expq.pop_front();
                if ({saida, led} !== mon_exp) begin
                    miscompares++;
                    $display("FAIL output_value: got %b, required %b", {saida, led}, mon_exp);
                end
            end
            prev = {saida, led};
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int lo, input int hi);
        vectors++;
        if (act < lo || act > hi) begin
            miscompares++;
            $display("FAIL %s: got %0d, required [%0d,%0d]", name, act, lo, hi);
        end
    endtask

    task automatic wait_change(input int maxc, output int n);
        logic [3:0] snap;
        snap = {saida, led};
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (({saida, led} === snap) && (n < maxc));
        if ({saida, led} === snap) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_change: no output change within %0d cycles, outputs %b", maxc, snap);
        end
    endtask

    task automatic press(input int z, input int c);
        pb[z] = 1'b1;
        cycles(c);
        pb[z] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1);
    end

    initial begin
        int n;

        cycles(3);
        chk("reset_saida", int'(saida), 0, 0);
        chk("reset_led", int'(led), 0, 0);
        rst  = 1'b0;
        prev = {saida, led};
        mon_en = 1'b1;

        cycles(1000);
        chk("idle_outputs", int'({saida, led}), 0, 0);

        // Zone0 one-cycle IR pulse: on after edge k+2, off ~50 ms later
        expq.push_back(4'b0100);
        expq.push_back(4'b0000);
        ir[0] = 1'b1;
        @(negedge clk);
        ir[0] = 1'b0;
        n = 1;
        while (saida[0] !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("ir_latency", n, 3, 3);
        wait_change(300, n);
        chk("ir_shutdown", n, 197, 201);

        // Zone1: bounce then 40 ms hold gives a single long press
        for (int i = 0; i < 5; i++) begin
            pb[1] = 1'b1;
            cycles(4);
            pb[1] = 1'b0;
            cycles(4);
        end
        expq.push_back(4'b0010);
        pb[1] = 1'b1;
        wait_change(200, n);
        chk("long_latency", n, 92, 95);
        cycles(160 - n);
        pb[1] = 1'b0;
        cycles(120);

        // Zone1 manual toggles
        expq.push_back(4'b1010);
        press(1, 40);
        wait_change(100, n);
        chk("short_on_latency", n, 12, 15);
        cycles(20);
        expq.push_back(4'b0010);
        press(1, 40);
        wait_change(100, n);
        chk("short_off_latency", n, 12, 15);
        cycles(20);
        expq.push_back(4'b1010);
        expq.push_back(4'b0010);
        press(1, 40);
        wait_change(100, n);
        wait_change(300, n);
        chk("manual_timeout", n, 197, 201);

        // Zone0 AUTO_ON then long press -> MANUAL_ON with lamp kept on
        expq.push_back(4'b0110);
        ir[0] = 1'b1;
        wait_change(10, n);
        chk("ir_latency_held", n, 3, 3);
        expq.push_back(4'b0111);
        pb[0] = 1'b1;
        wait_change(200, n);
        chk("long_auto_on", n, 92, 95);
        cycles(160 - n);
        pb[0] = 1'b0;
        cycles(40);

        // Reset in the middle of a press
        ir[0] = 1'b0;
        cycles(4);
        pb[0] = 1'b1;
        cycles(40);
        expq.push_back(4'b0000);
        rst = 1'b1;
        cycles(3);
        chk("midpress_reset", int'({saida, led}), 0, 0);
        pb[0] = 1'b0;
        rst = 1'b0;
        cycles(160);
        chk("post_reset_quiet", int'({saida, led}), 0, 0);

`ifdef ZLC_MASTER_OFF_EN
        expq.push_back(4'b0010);
        press(1, 160);
        cycles(40);
        expq.push_back(4'b1010);
        press(1, 40);
        cycles(40);
        expq.push_back(4'b1110);
        ir[0] = 1'b1;
        cycles(4);
        ir[0] = 1'b0;
        cycles(6);
        chk("both_on", int'({saida, led}), 14, 14);
        expq.push_back(4'b0010);
        all_off = 1'b1;
        @(negedge clk);
        all_off = 1'b0;
        chk("all_off", int'({saida, led}), 2, 2);
        cycles(20);
`endif

        chk("queue_drained", expq.size(), 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
